// File: rtl/quad_step_decoder.sv
// Quadrature (x4) step decoder: synchronizes enc_a/enc_b, skips a priming window
// after reset, then turns each legal phase edge into a count step and flags double-bit jumps.
module quad_step_decoder #(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             up_down,
    output logic             step,
    output logic             err
);

    localparam int unsigned PrimeW = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [PrimeW-1:0] PrimeLast = PrimeW'(SYNC_STAGES);

    typedef enum logic [0:0] {StPrime, StRun} state_e;

    logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
    logic [1:0]             cur;
    logic [1:0]             prev_q, prev_d;
    logic [3:0]             trans;
    logic                   dec_up, dec_dn, dec_err;

    state_e                 state_q, state_d;
    logic [PrimeW-1:0]      prime_cnt_q, prime_cnt_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic                   up_down_q, up_down_d;
    logic                   step_q, step_d;
    logic                   err_q, err_d;

    // Shift each phase through its own synchronizer chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
        end else begin
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], enc_a};
            b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], enc_b};
        end
    end

    assign cur    = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
    assign trans  = {prev_q, cur};
    assign prev_d = cur;

    // Classify the {prev, cur} transition: A leading is up, B leading is down.
    always_comb begin
        dec_up = 1'b0;
        dec_dn = 1'b0;
        case (trans)
            4'b0010, 4'b1011, 4'b1101, 4'b0100: dec_up = 1'b1;
            4'b0001, 4'b0111, 4'b1110, 4'b1000: dec_dn = 1'b1;
            default: ;
        endcase
        dec_err = ((prev_q ^ cur) == 2'b11);
    end

    // Next-state: priming countdown, then decode into count/direction/pulses.
    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        count_d     = count_q;
        up_down_d   = up_down_q;
        step_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            StPrime: begin
                // prev tracks cur here so pin levels at reset release never count as motion
                if (prime_cnt_q == PrimeLast) begin
                    state_d = StRun;
                end else begin
                    prime_cnt_d = prime_cnt_q + PrimeW'(1);
                end
            end
            StRun: begin
                if (dec_up) begin
                    count_d   = count_q + WIDTH'(1);
                    up_down_d = 1'b1;
                    step_d    = 1'b1;
                end else if (dec_dn) begin
                    count_d   = count_q - WIDTH'(1);
                    up_down_d = 1'b0;
                    step_d    = 1'b1;
                end
                err_d = dec_err;
            end
            default: state_d = StPrime;
        endcase
        // clear wins over a same-cycle step; step/up_down/err still report it
        if (clear) begin
            count_d = '0;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StPrime;
            prime_cnt_q <= '0;
            prev_q      <= 2'b00;
            count_q     <= '0;
            up_down_q   <= 1'b1;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            prev_q      <= prev_d;
            count_q     <= count_d;
            up_down_q   <= up_down_d;
            step_q      <= step_d;
            err_q       <= err_d;
        end
    end

    assign count   = count_q;
    assign up_down = up_down_q;
    assign step    = step_q;
    assign err     = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: stimulus pushes expected step/err events,
// a negedge monitor pops and compares each pulse the DUT presents.
module tb_quad_step_decoder;

    localparam int unsigned WIDTH = 3;
    localparam int unsigned SYNC  = 2;

    typedef struct {
        logic [WIDTH-1:0] cnt;
        logic             dir;
        logic             stp;
        logic             er;
        int               cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             enc_a = 1'b1;
    logic             enc_b = 1'b1;
    logic             clear = 1'b0;
    logic [WIDTH-1:0] count;
    logic             up_down;
    logic             step;
    logic             err;

    exp_t             sb[$];
    int               cyc = 0;
    int               n_cmp = 0;
    int               n_bad = 0;

    // model state
    logic [1:0]       pins = 2'b11;
    logic [WIDTH-1:0] exp_cnt = '0;
    logic             exp_dir = 1'b1;

    quad_step_decoder #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enc_a  (enc_a),
        .enc_b  (enc_b),
        .clear  (clear),
        .count  (count),
        .up_down(up_down),
        .step   (step),
        .err    (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every step/err pulse must match the oldest expected event
    always @(negedge clk) begin
        if (step || err) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event cyc=%0d got cnt=%0d dir=%0b step=%0b err=%0b, expected none",
                         cyc, count, up_down, step, err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (count !== e.cnt || up_down !== e.dir || step !== e.stp || err !== e.er
                    || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL event got cnt=%0d dir=%0b step=%0b err=%0b cyc=%0d, expected cnt=%0d dir=%0b step=%0b err=%0b cyc=%0d",
                             count, up_down, step, err, cyc, e.cnt, e.dir, e.stp, e.er, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s got %0h expected %0h", name, act, expv);
        end
    endtask

    // Idle-state check: count, direction, and no pulses.
    task automatic chk_idle(input string name, input logic [WIDTH-1:0] c);
        chk(name, {3'b0, count, up_down, step, err}, {3'b0, c, 1'b1, 1'b0, 1'b0});
    endtask

    // Drive one phase pattern, record the expected event, hold for 'hold' clocks.
    task automatic phase(input logic [1:0] p, input bit do_clr, input int hold);
        logic [3:0] t;
        bit         up, dn, bad;
        exp_t       e;
        int         n;
        @(posedge clk);
        #1;
        enc_a = p[1];
        enc_b = p[0];
        t   = {pins, p};
        up  = (t == 4'b0010) || (t == 4'b1011) || (t == 4'b1101) || (t == 4'b0100);
        dn  = (t == 4'b0001) || (t == 4'b0111) || (t == 4'b1110) || (t == 4'b1000);
        bad = (t == 4'b0011) || (t == 4'b1100) || (t == 4'b0110) || (t == 4'b1001);
        if (up) begin
            exp_cnt = exp_cnt + 1'b1;
            exp_dir = 1'b1;
        end else if (dn) begin
            exp_cnt = exp_cnt - 1'b1;
            exp_dir = 1'b0;
        end
        if (do_clr) exp_cnt = '0;
        if (up || dn || bad) begin
            e.cnt = exp_cnt;
            e.dir = exp_dir;
            e.stp = up || dn;
            e.er  = bad;
            e.cyc = cyc + SYNC + 1;
            sb.push_back(e);
        end
        pins = p;
        n = hold - 1;
        if (do_clr) begin
            // line clear up with the edge that decodes this transition
            repeat (SYNC) @(posedge clk);
            #1 clear = 1'b1;
            @(posedge clk);
            #1 clear = 1'b0;
            n = n - 3;
        end
        repeat (n) @(posedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset with pins at 11, then prime
        repeat (3) begin
            @(negedge clk);
            chk_idle("reset_hold", '0);
        end
        #2 reset = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk_idle("prime_11", '0);
        end

        // fresh reset with pins at 00 for the sequence tests
        #2 reset = 1'b0;
        enc_a = 1'b0;
        enc_b = 1'b0;
        pins    = 2'b00;
        exp_cnt = '0;
        exp_dir = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        repeat (5) @(negedge clk);
        chk_idle("prime_00", '0);

        // 2: up sequence 1..4
        phase(2'b10, 0, 4);
        phase(2'b11, 0, 4);
        phase(2'b01, 0, 4);
        phase(2'b00, 0, 4);
        @(negedge clk);
        chk("count_after_up4", {5'b0, count}, 8'd4);

        // 3: up to 7, wrap to 0, down wrap to 7
        phase(2'b10, 0, 4);
        phase(2'b11, 0, 4);
        phase(2'b01, 0, 4);
        phase(2'b00, 0, 4);
        @(negedge clk);
        chk("wrap_up", {4'b0, count, up_down}, {4'b0, 3'd0, 1'b1});
        phase(2'b01, 0, 4);
        @(negedge clk);
        chk("wrap_down", {4'b0, count, up_down}, {4'b0, 3'd7, 1'b0});

        // 4: up to 0, then illegal 00->11, then 11->01 counts up
        phase(2'b00, 0, 4);
        phase(2'b11, 0, 4);
        @(negedge clk);
        chk("illegal_hold", {5'b0, count}, 8'd0);
        phase(2'b01, 0, 4);
        @(negedge clk);
        chk("after_illegal", {5'b0, count}, 8'd1);

        // 5: climb to 5, then down step colliding with clear
        phase(2'b00, 0, 4);
        phase(2'b10, 0, 4);
        phase(2'b11, 0, 4);
        phase(2'b01, 0, 4);
        @(negedge clk);
        chk("count_5", {5'b0, count}, 8'd5);
        phase(2'b11, 1, 5);
        @(negedge clk);
        chk("clear_collision", {4'b0, count, up_down}, {4'b0, 3'd0, 1'b0});

        // 6: climb to 3, then async reset mid-run
        phase(2'b01, 0, 4);
        phase(2'b00, 0, 4);
        phase(2'b10, 0, 4);
        @(negedge clk);
        chk("count_3", {5'b0, count}, 8'd3);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk_idle("async_reset", '0);
        exp_cnt = '0;
        exp_dir = 1'b1;
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (SYNC + 1) begin
            @(negedge clk);
            chk_idle("reprime", '0);
        end
        phase(2'b11, 0, 4);
        @(negedge clk);
        chk("run_after_reprime", {4'b0, count, up_down}, {4'b0, 3'd1, 1'b1});

        repeat (6) @(negedge clk);
        chk("scoreboard_drained", sb.size() > 255 ? 8'hff : 8'(sb.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
